// File: rtl/mantissa_mult_seq.sv
// Sequential radix-2 shift-add significand multiplier for the single-precision FMUL path.
// Takes two WIDTH-bit significands and returns the raw 2*WIDTH-bit product after WIDTH iterations.
module mantissa_mult_seq #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 norm_shift
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic [PW-1:0]      acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               norm_q,  norm_d;

    logic               last_iter;
    logic [PW-1:0]      partial_sum;

    assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
    // The add cannot carry out: the running sum never exceeds a_in*b_in < 2^PW.
    assign partial_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            norm_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            norm_q    <= norm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath: operands load on the accepting edge, then one shift-add step per BUSY cycle.
    always_comb begin
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        norm_d    = norm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = {{WIDTH{1'b0}}, a_in};
                    mplr_d  = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d   = partial_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    product_d = partial_sum;
                    norm_d    = partial_sum[PW-1];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign product_out = product_q;
    assign norm_shift  = norm_q;

endmodule
